vga_crtc_regs: RTL and testbench



---
 rtl/vga_crtc_regs.sv | 228 ++++++++++++++++++++++
 tb/tb_vga_crtc_regs.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_crtc_regs.sv
// vga_crtc_regs: CRTC index/data register file with shadow/active copies.
// Shadow writes are committed to the active copies atomically at the start of
// vertical sync. Also holds a frame counter, a vsync interrupt and
// status/control registers.
//
// Bus handshake: an access is cs & data_m_access. Every accepted access is
// acknowledged exactly one cycle later on data_m_ack, and data_m_data_out
// carries the read data in that ack cycle (16'h0 after writes and idle cycles).
// Back-to-back accesses are allowed; there is no stall.
//
// Optional feature: define VGA_CRTC_AUTOINC_EN to auto-increment the stored
// index after every data-register access.
module vga_crtc_regs #(
    parameter int NUM_REGS        = 16,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cs,
    input  logic [19:1]           data_m_addr,
    input  logic [15:0]           data_m_data_in,
    output logic [15:0]           data_m_data_out,
    input  logic [1:0]            data_m_bytesel,
    input  logic                  data_m_wr_en,
    input  logic                  data_m_access,
    output logic                  data_m_ack,
    input  logic                  vga_hsync,
    input  logic                  vga_vsync,
    output logic [NUM_REGS*8-1:0] regs_active,
    output logic                  irq
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // vs_prev holds the raw pin level; its reset value is the active level so a
    // vsync already active at reset release does not count as a new frame.
    localparam logic VS_PREV_RST = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

    logic [7:0]       shadow [NUM_REGS];
    logic [7:0]       active [NUM_REGS];
    logic [IDX_W-1:0] index_q;
    logic             dirty_q;
    logic             irq_en_q;
    logic             immediate_q;
    logic             irq_pending_q;
    logic [7:0]       frame_cnt_q;
    logic             vs_prev_q;

    logic             acc;
    logic             wr;
    logic             rd;
    logic             sel_idx;
    logic             sel_stat;
    logic             sel_ctrl;
    logic             idx_wr;
    logic             data_acc;
    logic             data_wr;
    logic             data_upd;
    logic             stat_clr;
    logic             ctrl_wr;
    logic             vs_act;
    logic             hs_act;
    logic             vs_prev_act;
    logic             vs_start;
    logic             commit;
    logic [IDX_W-1:0] eff_idx;
    logic             in_range;
    logic [7:0]       shadow_rd;
    logic [7:0]       rd_lo;
    logic [7:0]       rd_hi;
    logic [15:0]      rd_word;

    assign acc      = cs & data_m_access;
    assign wr       = acc & data_m_wr_en;
    assign rd       = acc & ~data_m_wr_en;
    assign sel_idx  = (data_m_addr[3:1] == 3'b010);
    assign sel_stat = (data_m_addr[3:1] == 3'b101);
    assign sel_ctrl = (data_m_addr[3:1] == 3'b110);

    assign idx_wr   = wr & sel_idx & data_m_bytesel[0];
    assign data_acc = acc & sel_idx & data_m_bytesel[1];
    assign data_wr  = data_acc & data_m_wr_en;
    assign data_upd = data_wr & in_range;
    assign stat_clr = wr & sel_stat & data_m_bytesel[0] & data_m_data_in[7];
    assign ctrl_wr  = wr & sel_ctrl & data_m_bytesel[0];

    assign vs_act      = vga_vsync ^ SYNC_ACTIVE_LOW;
    assign hs_act      = vga_hsync ^ SYNC_ACTIVE_LOW;
    assign vs_prev_act = vs_prev_q ^ SYNC_ACTIVE_LOW;
    assign vs_start    = vs_act & ~vs_prev_act;
    assign commit      = vs_start & dirty_q;

    // A same-access index write redirects the data lane to the new index.
    assign eff_idx = idx_wr ? data_m_data_in[IDX_W-1:0] : index_q;

    // Select the addressed shadow byte; out-of-range indices read as zero.
    always_comb begin
        in_range  = 1'b0;
        shadow_rd = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (eff_idx == IDX_W'(i)) begin
                in_range  = 1'b1;
                shadow_rd = shadow[i];
            end
        end
    end

    // Read mux; unselected lanes and unmapped offsets return zero.
    always_comb begin
        rd_lo = 8'h00;
        rd_hi = 8'h00;
        case (data_m_addr[3:1])
            3'b010: begin
                rd_lo = 8'(index_q);
                rd_hi = shadow_rd;
            end
            3'b101: begin
                rd_lo = {irq_pending_q, 2'b00, dirty_q, vs_act, 2'b00, hs_act | vs_act};
            end
            3'b110: begin
                rd_lo = {6'b000000, immediate_q, irq_en_q};
                rd_hi = frame_cnt_q;
            end
            default: begin
                rd_lo = 8'h00;
                rd_hi = 8'h00;
            end
        endcase
        rd_word = {data_m_bytesel[1] ? rd_hi : 8'h00,
                   data_m_bytesel[0] ? rd_lo : 8'h00};
    end

    // Bus response: one-cycle ack, read data only in cycles after a read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_m_ack      <= 1'b0;
            data_m_data_out <= 16'h0000;
        end else begin
            data_m_ack      <= acc;
            data_m_data_out <= rd ? rd_word : 16'h0000;
        end
    end

    // Index register, with optional post-access auto-increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index_q <= '0;
        end else begin
`ifdef VGA_CRTC_AUTOINC_EN
            if (data_acc) begin
                index_q <= (eff_idx == IDX_W'(NUM_REGS - 1)) ? '0 : eff_idx + IDX_W'(1);
            end else if (idx_wr) begin
                index_q <= eff_idx;
            end
`else
            if (idx_wr) begin
                index_q <= eff_idx;
            end
`endif
        end
    end

    // Control bits, dirty flag and interrupt pending (vsync set beats clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q      <= 1'b0;
            immediate_q   <= 1'b0;
            dirty_q       <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en_q    <= data_m_data_in[0];
                immediate_q <= data_m_data_in[1];
            end
            if (data_upd && !immediate_q) begin
                dirty_q <= 1'b1;
            end else if (vs_start) begin
                dirty_q <= 1'b0;
            end
            if (vs_start) begin
                irq_pending_q <= 1'b1;
            end else if (stat_clr) begin
                irq_pending_q <= 1'b0;
            end
        end
    end

    // Shadow/active arrays: commit copies pre-write shadow; immediate writes win.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= 8'h00;
                active[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit) begin
                    active[i] <= shadow[i];
                end
                if (data_upd && (eff_idx == IDX_W'(i))) begin
                    shadow[i] <= data_m_data_in[15:8];
                    if (immediate_q) begin
                        active[i] <= data_m_data_in[15:8];
                    end
                end
            end
        end
    end

    // Vsync edge history and frame counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev_q   <= VS_PREV_RST;
            frame_cnt_q <= 8'h00;
        end else begin
            vs_prev_q <= vga_vsync;
            if (vs_start) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_active_out
        assign regs_active[8*g+7:8*g] = active[g];
    end

    assign irq = irq_pending_q & irq_en_q;

endmodule

// File: tb/tb_vga_crtc_regs.sv
// tb_vga_crtc_regs: scoreboard bench for vga_crtc_regs (NUM_REGS=16,
// active-low syncs). A reference model of the register file tracks the
// expected state; reads push expected data onto exp_q and a monitor pops
// and compares on every ack.
module tb_vga_crtc_regs;

    localparam int NR = 16;

    logic          clk;
    logic          reset_n;
    logic          cs;
    logic [19:1]   data_m_addr;
    logic [15:0]   data_m_data_in;
    logic [15:0]   data_m_data_out;
    logic [1:0]    data_m_bytesel;
    logic          data_m_wr_en;
    logic          data_m_access;
    logic          data_m_ack;
    logic          vga_hsync;
    logic          vga_vsync;
    logic [NR*8-1:0] regs_active;
    logic          irq;

    vga_crtc_regs #(.NUM_REGS(NR), .SYNC_ACTIVE_LOW(1'b1)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cs              (cs),
        .data_m_addr     (data_m_addr),
        .data_m_data_in  (data_m_data_in),
        .data_m_data_out (data_m_data_out),
        .data_m_bytesel  (data_m_bytesel),
        .data_m_wr_en    (data_m_wr_en),
        .data_m_access   (data_m_access),
        .data_m_ack      (data_m_ack),
        .vga_hsync       (vga_hsync),
        .vga_vsync       (vga_vsync),
        .regs_active     (regs_active),
        .irq             (irq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];

    // ---------------- reference model ----------------
    logic [7:0] m_shadow [NR];
    logic [7:0] m_active [NR];
    int         m_index;
    bit         m_dirty;
    bit         m_irq_en;
    bit         m_imm;
    bit         m_pend;
    bit         m_vs_prev;
    int         m_fcnt;

    task automatic check(input string name, input logic [NR*8-1:0] got, input logic [NR*8-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_shadow[i] = 8'h00;
            m_active[i] = 8'h00;
        end
        m_index   = 0;
        m_dirty   = 0;
        m_irq_en  = 0;
        m_imm     = 0;
        m_pend    = 0;
        m_vs_prev = 1;
        m_fcnt    = 0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (data_m_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: got ack with data %h, required no ack", data_m_data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data", 128'(data_m_data_out), 128'(e));
                end
            end else begin
                check("idle_data_zero", 128'(data_m_data_out), 128'h0);
            end
        end
    end

    // ---------------- driver ----------------
    // One clock cycle of stimulus; the model advances by the same cycle.
    task automatic cycle(input bit c, input bit ac, input bit [2:0] a, input bit [1:0] be,
                         input bit w, input bit [15:0] d, input bit vs, input bit hs);
        logic [NR*8-1:0] exp_act;
        logic [7:0]      lo;
        logic [7:0]      hi;
        bit              acc;
        bit              vs_start;
        int              eff;
        @(negedge clk);
        for (int i = 0; i < NR; i++) exp_act[8*i +: 8] = m_active[i];
        check("regs_active", regs_active, exp_act);
        check("irq", 128'(irq), 128'(m_pend & m_irq_en));

        cs             = c;
        data_m_access  = ac;
        data_m_addr    = {16'($urandom), a};
        data_m_bytesel = be;
        data_m_wr_en   = w;
        data_m_data_in = d;
        vga_vsync      = vs ? 1'b0 : 1'b1;
        vga_hsync      = hs ? 1'b0 : 1'b1;

        acc      = c & ac;
        vs_start = vs && !m_vs_prev;
        m_vs_prev = vs;
        eff = (acc && w && a == 3'd2 && be[0]) ? int'(d[3:0]) : m_index;

        if (acc) begin
            lo = 8'h00;
            hi = 8'h00;
            if (!w) begin
                if (a == 3'd2) begin
                    lo = 8'(m_index);
                    hi = (m_index < NR) ? m_shadow[m_index] : 8'h00;
                end else if (a == 3'd5) begin
                    lo = {m_pend, 2'b00, m_dirty, vs, 2'b00, vs | hs};
                end else if (a == 3'd6) begin
                    lo = {6'b0, m_imm, m_irq_en};
                    hi = 8'(m_fcnt);
                end
                if (!be[0]) lo = 8'h00;
                if (!be[1]) hi = 8'h00;
            end
            exp_q.push_back({hi, lo});
        end

        if (acc && w && a == 3'd5 && be[0] && d[7]) m_pend = 0;
        if (vs_start) begin
            if (m_dirty) begin
                for (int i = 0; i < NR; i++) m_active[i] = m_shadow[i];
                m_dirty = 0;
            end
            m_fcnt = (m_fcnt + 1) % 256;
            m_pend = 1;
        end
        if (acc && w && a == 3'd2) begin
            if (be[0]) m_index = int'(d[3:0]);
            if (be[1] && eff < NR) begin
                m_shadow[eff] = d[15:8];
                if (m_imm) m_active[eff] = d[15:8];
                else       m_dirty = 1;
            end
        end
        if (acc && w && a == 3'd6 && be[0]) begin
            m_irq_en = d[0];
            m_imm    = d[1];
        end
`ifdef VGA_CRTC_AUTOINC_EN
        if (acc && a == 3'd2 && be[1]) m_index = (eff + 1) % NR;
`endif
    endtask

    task automatic wr(input bit [2:0] a, input bit [1:0] be, input bit [15:0] d, input bit vs = 1'b0);
        cycle(1, 1, a, be, 1, d, vs, 0);
    endtask

    task automatic rd(input bit [2:0] a, input bit [1:0] be);
        cycle(1, 1, a, be, 0, 16'($urandom), 0, 0);
    endtask

    task automatic idle(input int n, input bit vs = 1'b0);
        repeat (n) cycle(0, 0, 3'd0, 2'd0, 0, 16'h0, vs, 0);
    endtask

    task automatic vs_pulse();
        idle(1, 1'b1);
        idle(1, 1'b0);
    endtask

    // Reset with vsync held at the given level across release.
    task automatic apply_reset(input bit vs);
        @(negedge clk);
        reset_n        = 1'b0;
        cs             = 1'b0;
        data_m_access  = 1'b0;
        data_m_wr_en   = 1'b0;
        data_m_bytesel = 2'b00;
        data_m_data_in = 16'h0;
        vga_vsync      = vs ? 1'b0 : 1'b1;
        vga_hsync      = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_regs_active", regs_active, '0);
        check("rst_irq", 128'(irq), 128'h0);
        check("rst_ack", 128'(data_m_ack), 128'h0);
        @(negedge clk);
        reset_n   = 1'b1;
        m_vs_prev = vs;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] picks [8];
        bit         vs_r;
        picks = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd6, 3'd6, 3'd3};
        reset_n        = 1'b1;
        cs             = 1'b0;
        data_m_access  = 1'b0;
        data_m_addr    = '0;
        data_m_data_in = 16'h0;
        data_m_bytesel = 2'b00;
        data_m_wr_en   = 1'b0;
        vga_vsync      = 1'b1;
        vga_hsync      = 1'b1;
        #1 reset_n = 1'b0;
        apply_reset(1'b0);

        // Reset contents.
        rd(3'd5, 2'b01);
        rd(3'd6, 2'b01);
        rd(3'd2, 2'b10);
        rd(3'd2, 2'b11);

        // Shadow write, then commit on vsync.
        wr(3'd2, 2'b01, 16'h0003);
        wr(3'd2, 2'b10, 16'hA500);
        rd(3'd5, 2'b01);
        idle(2);
        vs_pulse();
        rd(3'd5, 2'b01);
        idle(1);

        // Data write coinciding with vs_start.
        wr(3'd2, 2'b01, 16'h0002);
        wr(3'd2, 2'b10, 16'h2200);
        wr(3'd2, 2'b10, 16'h1100, 1'b1);
        idle(1);
        wr(3'd2, 2'b01, 16'h0002);
        rd(3'd2, 2'b10);
        rd(3'd5, 2'b01);
        vs_pulse();
        idle(1);

        // Interrupt enable, clear, and clear racing the set.
        wr(3'd6, 2'b01, 16'h0001);
        vs_pulse();
        idle(1);
        wr(3'd5, 2'b01, 16'h0080);
        idle(1);
        vs_pulse();
        wr(3'd5, 2'b01, 16'h0080, 1'b1);
        idle(2);
        rd(3'd5, 2'b01);

        // Mid-frame reset discards shadow; vsync active across release.
        wr(3'd2, 2'b01, 16'h0005);
        wr(3'd2, 2'b10, 16'h5500);
        idle(1);
        apply_reset(1'b1);
        idle(3, 1'b1);
        cycle(1, 1, 3'd6, 2'b11, 0, 16'h0, 1, 0);
        idle(1);
        wr(3'd2, 2'b01, 16'h0005);
        rd(3'd2, 2'b10);

        // Frame counter wrap: 300 frames from reset.
        repeat (300) vs_pulse();
        rd(3'd6, 2'b10);
        wr(3'd6, 2'b10, 16'hFF00);
        rd(3'd6, 2'b11);

        // Immediate mode, index and data in one access.
        wr(3'd6, 2'b01, 16'h0002);
        wr(3'd2, 2'b11, 16'h7E00);
        idle(1);
        wr(3'd6, 2'b01, 16'h0000);

        // Index 15 followed by two data writes.
        wr(3'd2, 2'b01, 16'h000F);
        wr(3'd2, 2'b10, 16'h0100);
        wr(3'd2, 2'b10, 16'h0200);
        rd(3'd2, 2'b01);
        wr(3'd2, 2'b01, 16'h000F);
        rd(3'd2, 2'b10);
        wr(3'd2, 2'b01, 16'h0000);
        rd(3'd2, 2'b10);
        vs_pulse();
        idle(1);

        // Randomized traffic with random sync activity.
        vs_r = 0;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 5) == 0) vs_r = ~vs_r;
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                  picks[$urandom_range(0, 7)], 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, 16'($urandom), vs_r,
                  $urandom_range(0, 3) == 0);
        end

        idle(4);
        check("pending_acks", 128'(exp_q.size()), 128'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
